// File: rtl/serial_adder_n.sv
// Bit-serial adder/subtractor: adds or subtracts two WIDTH-bit operands one bit
// per clock, LSB first, and reports carry, signed overflow and a done pulse.
module serial_adder_n #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             overflow,
    output logic             state,
    output logic             y
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       r_fsm;
    logic [WIDTH-1:0] r_aSh;
    logic [WIDTH-1:0] r_bSh;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_sum;
    logic             r_carry;
    logic             r_carryOut;
    logic             r_overflow;

    logic             w_y;
    logic             w_carryNext;

    // Full adder on the current LSBs; subtraction arrives as a + ~b + 1 via the seeded carry.
    assign w_y         = r_aSh[0] ^ r_bSh[0] ^ r_carry;
    assign w_carryNext = (r_aSh[0] & r_bSh[0]) | (r_carry & (r_aSh[0] | r_bSh[0]));

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_fsm      <= IDLE;
            r_aSh      <= '0;
            r_bSh      <= '0;
            r_cnt      <= '0;
            r_sum      <= '0;
            r_carry    <= 1'b0;
            r_carryOut <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            case (r_fsm)
                IDLE: begin
                    if (start) begin
                        r_aSh   <= a;
                        r_bSh   <= op ? ~b : b;
                        r_carry <= op;
                        r_cnt   <= '0;
                        r_fsm   <= RUN;
                    end
                end
                RUN: begin
                    r_carry <= w_carryNext;
                    r_sum   <= {w_y, r_sum[WIDTH-1:1]};
                    r_aSh   <= r_aSh >> 1;
                    r_bSh   <= r_bSh >> 1;
                    r_cnt   <= r_cnt + 1'b1;
                    // Last bit is the MSB: carry in vs. carry out gives signed overflow.
                    if (r_cnt == CNT_W'(WIDTH - 1)) begin
                        r_overflow <= r_carry ^ w_carryNext;
                        r_carryOut <= w_carryNext;
                        r_fsm      <= DONE;
                    end
                end
                DONE: begin
                    r_fsm <= IDLE;
                end
                default: begin
                    r_fsm <= IDLE;
                end
            endcase
        end
    end

    assign busy      = (r_fsm != IDLE);
    assign done      = (r_fsm == DONE);
    assign sum       = r_sum;
    assign carry_out = r_carryOut;
    assign overflow  = r_overflow;
    assign state     = r_carry;
    assign y         = w_y;

endmodule

// File: tb/tb_serial_adder_n.sv
// Bench for serial_adder_n: directed corner cases, held-start and abort scenarios,
// then random operations compared against an integer-arithmetic model.
module tb_serial_adder_n;

    localparam int WIDTH = 8;
    localparam int CNT_W = 6;

    logic             clk;
    logic             reset;
    logic             start;
    logic             op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             carry_out;
    logic             overflow;
    logic             state;
    logic             y;

    int compared   = 0;
    int mismatched = 0;

    serial_adder_n #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .op        (op),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .done      (done),
        .sum       (sum),
        .carry_out (carry_out),
        .overflow  (overflow),
        .state     (state),
        .y         (y)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        compared++;
        assert (obs === expv) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    // Reference result from plain integer arithmetic: {overflow, carry_out, sum}.
    function automatic logic [WIDTH+1:0] model(input logic [WIDTH-1:0] ma, input logic [WIDTH-1:0] mb,
                                                input logic mop);
        int ua, ub, sa, sb, ur, sr;
        logic [WIDTH-1:0] r;
        logic c, v;
        ua = int'(ma);
        ub = int'(mb);
        sa = ma[WIDTH-1] ? ua - (1 << WIDTH) : ua;
        sb = mb[WIDTH-1] ? ub - (1 << WIDTH) : ub;
        if (mop) begin
            ur = ua - ub;
            c  = (ua >= ub);
            sr = sa - sb;
        end else begin
            ur = ua + ub;
            c  = (ur >= (1 << WIDTH));
            sr = sa + sb;
        end
        r = WIDTH'(ur);
        v = (sr > (1 << (WIDTH - 1)) - 1) || (sr < -(1 << (WIDTH - 1)));
        return {v, c, r};
    endfunction

    // One operation; optional start/operand intrusion at RUN cycle injectAt,
    // optional reset asserted at RUN cycle resetAt (aborts the operation).
    task automatic applyStimulus(input string tag, input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tbv,
                                 input logic top, input int injectAt, input int resetAt);
        logic [WIDTH+1:0] expv;
        logic [WIDTH-1:0] ySeen;
        int latency;
        bit seenDone;
        bit busyGap;
        expv     = model(ta, tbv, top);
        ySeen    = '0;
        latency  = 0;
        seenDone = 1'b0;
        busyGap  = 1'b0;
        @(negedge clk);
        start = 1'b1;
        a     = ta;
        b     = tbv;
        op    = top;
        @(negedge clk);
        start = 1'b0;
        for (int idx = 1; idx <= 4 * WIDTH; idx++) begin
            if (resetAt != 0 && idx == resetAt) begin
                reset = 1'b0;
                @(negedge clk);
                reset = 1'b1;
                checkOutput({tag, " abort busy"}, 32'(busy), 32'd0);
                checkOutput({tag, " abort sum"}, 32'(sum), 32'd0);
                checkOutput({tag, " abort done"}, 32'(done), 32'd0);
                @(negedge clk);
                checkOutput({tag, " abort no done"}, 32'(done), 32'd0);
                return;
            end
            if (injectAt != 0 && idx == injectAt) begin
                start = 1'b1;
                a     = ~ta;
                b     = ta;
                op    = ~top;
            end
            if (injectAt != 0 && idx == injectAt + 1) start = 1'b0;
            if (done) begin
                seenDone = 1'b1;
                latency  = idx;
                break;
            end
            if (!busy) busyGap = 1'b1;
            if (idx <= WIDTH) ySeen[idx-1] = y;
            @(negedge clk);
        end
        start = 1'b0;
        checkOutput({tag, " done seen"}, 32'(seenDone), 32'd1);
        checkOutput({tag, " latency"}, 32'(latency), 32'(WIDTH + 1));
        checkOutput({tag, " busy continuous"}, 32'(busyGap), 32'd0);
        checkOutput({tag, " busy at done"}, 32'(busy), 32'd1);
        checkOutput({tag, " sum"}, 32'(sum), 32'(expv[WIDTH-1:0]));
        checkOutput({tag, " carry_out"}, 32'(carry_out), 32'(expv[WIDTH]));
        checkOutput({tag, " overflow"}, 32'(overflow), 32'(expv[WIDTH+1]));
        checkOutput({tag, " serial y"}, 32'(ySeen), 32'(expv[WIDTH-1:0]));
        @(negedge clk);
        checkOutput({tag, " done pulse width"}, 32'(done), 32'd0);
        checkOutput({tag, " idle busy"}, 32'(busy), 32'd0);
        checkOutput({tag, " sum held"}, 32'(sum), 32'(expv[WIDTH-1:0]));
    endtask

    initial begin
        logic [WIDTH+1:0] expv;
        logic [WIDTH-1:0] ySub;
        int doneTimes[$];
        reset = 1'b0;
        start = 1'b1;
        op    = 1'b0;
        a     = 8'h12;
        b     = 8'h34;

        // Reset wins over a simultaneous start.
        repeat (3) @(negedge clk);
        checkOutput("reset busy", 32'(busy), 32'd0);
        checkOutput("reset done", 32'(done), 32'd0);
        checkOutput("reset sum", 32'(sum), 32'd0);
        checkOutput("reset carry_out", 32'(carry_out), 32'd0);
        checkOutput("reset overflow", 32'(overflow), 32'd0);
        checkOutput("reset state", 32'(state), 32'd0);
        start = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        checkOutput("post-reset idle", 32'(busy), 32'd0);

        applyStimulus("add 0F+01", 8'h0F, 8'h01, 1'b0, 0, 0);
        applyStimulus("add FF+01", 8'hFF, 8'h01, 1'b0, 0, 0);
        applyStimulus("add 7F+01", 8'h7F, 8'h01, 1'b0, 0, 0);
        applyStimulus("sub 80-01", 8'h80, 8'h01, 1'b1, 0, 0);
        applyStimulus("sub 05-07", 8'h05, 8'h07, 1'b1, 0, 0);
        ySub = 8'hFE;
        checkOutput("sub 05-07 literal sum", 32'(sum), 32'(ySub));
        applyStimulus("ignored start", 8'h3C, 8'h5A, 1'b0, 3, 0);
        applyStimulus("abort", 8'hA5, 8'h17, 1'b0, 0, 4);
        applyStimulus("after abort", 8'h21, 8'h43, 1'b1, 0, 0);

        // Held start: consecutive done pulses spaced WIDTH+2 cycles apart.
        @(negedge clk);
        a     = 8'h9C;
        b     = 8'h77;
        op    = 1'b0;
        start = 1'b1;
        for (int cyc = 0; cyc < 6 * WIDTH && doneTimes.size() < 2; cyc++) begin
            @(negedge clk);
            if (done) doneTimes.push_back(cyc);
        end
        start = 1'b0;
        checkOutput("held start two dones", 32'(doneTimes.size()), 32'd2);
        if (doneTimes.size() == 2)
            checkOutput("held start spacing", 32'(doneTimes[1] - doneTimes[0]), 32'(WIDTH + 2));
        expv = model(8'h9C, 8'h77, 1'b0);
        checkOutput("held start sum", 32'(sum), 32'(expv[WIDTH-1:0]));
        repeat (2) @(negedge clk);

        for (int n = 0; n < 20; n++) begin
            applyStimulus($sformatf("random %0d", n), WIDTH'($urandom), WIDTH'($urandom),
                          1'($urandom_range(0, 1)), 0, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
